// File: rtl/bus_address_router.sv
// -----------------------------------------------------------------------------
// bus_address_router
//
// Routes single-cycle CPU data-bus requests to one of NUM_TARGETS targets by
// base/mask window decode. One transaction is tracked at a time; the selected
// target's ack/rdata is muxed back to the CPU. Unmapped addresses and targets
// that stay silent for TIMEOUT_CYCLES get an error ack carrying ERR_RDATA.
//
// Optional feature: define BUS_ERROR_LOG_EN to add a sticky capture of the
// address of the first failing request (err_valid / err_addr / err_clear).
//
// Ports
//   clock         in   1        system clock
//   resetn        in   1        synchronous active-low reset
//   cpud_request  in   1        CPU request strobe, single cycle
//   cpud_addr     in   32       CPU address, valid with cpud_request
//   cpud_ack      out  1        transaction complete
//   cpud_error    out  1        with cpud_ack: unmapped address or timeout
//   cpud_rdata    out  32       read data, valid with cpud_ack, else 0
//   tgt_req       out  NT       one-hot request pulse to target i
//   tgt_ack       in   NT       per-target ack
//   err_valid     out  1        [BUS_ERROR_LOG_EN] sticky error-captured flag
//   err_addr      out  32       [BUS_ERROR_LOG_EN] address of first error
//   err_clear     in   1        [BUS_ERROR_LOG_EN] clears err_valid
//   tgt_rdata     in   NT*32    per-target read data, target i at [32*i+:32]
// -----------------------------------------------------------------------------
module bus_address_router #(
    parameter int                          NUM_TARGETS    = 3,
    parameter logic [NUM_TARGETS*32-1:0]   TARGET_BASE    = {32'hE0010000, 32'hE0000000, 32'h0},
    parameter logic [NUM_TARGETS*32-1:0]   TARGET_MASK    = {32'hFFFF0000, 32'hFFFF0000, 32'hFC000000},
    parameter int                          TIMEOUT_CYCLES = 255,
    parameter logic [31:0]                 ERR_RDATA      = 32'hDEADBEEF
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      cpud_request,
    input  logic [31:0]               cpud_addr,
    output logic                      cpud_ack,
    output logic                      cpud_error,
    output logic [31:0]               cpud_rdata,
    output logic [NUM_TARGETS-1:0]    tgt_req,
    input  logic [NUM_TARGETS-1:0]    tgt_ack,
`ifdef BUS_ERROR_LOG_EN
    output logic                      err_valid,
    output logic [31:0]               err_addr,
    input  logic                      err_clear,
`endif
    input  logic [NUM_TARGETS*32-1:0] tgt_rdata
);

    localparam int SEL_W = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [TW-1:0]     timer_q, timer_d;

    logic              hit;
    logic [SEL_W-1:0]  dec_sel;
    logic [SEL_W-1:0]  cur_sel;
    logic              cur_ack;
    logic [31:0]       cur_rdata;

    // Window decode. Scanning from the top index down lets the lowest
    // matching index overwrite the others, so the lowest hit wins.
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no latch is inferred and later lines see earlier ones.
    always_comb begin
        hit     = 1'b0;
        dec_sel = '0;
        for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
            if (((cpud_addr ^ TARGET_BASE[32*i +: 32]) & TARGET_MASK[32*i +: 32]) == 32'd0) begin
                hit     = 1'b1;
                dec_sel = SEL_W'(i);
            end
        end
    end

    // In IDLE the freshly decoded target is the one that may ack (0-cycle
    // pass-through); afterwards only the registered selection is listened to.
    assign cur_sel = (state_q == S_IDLE) ? dec_sel : sel_q;

    always_comb begin
        cur_ack   = 1'b0;
        cur_rdata = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            if (SEL_W'(i) == cur_sel) begin
                cur_ack   = tgt_ack[i];
                cur_rdata = tgt_rdata[32*i +: 32];
            end
        end
    end

    // Next-state and outputs.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        timer_d    = timer_q;
        tgt_req    = '0;
        cpud_ack   = 1'b0;
        cpud_error = 1'b0;
        cpud_rdata = '0;

        case (state_q)
            S_IDLE: begin
                if (cpud_request) begin
                    if (hit) begin
                        for (int i = 0; i < NUM_TARGETS; i++) begin
                            tgt_req[i] = (SEL_W'(i) == dec_sel);
                        end
                        sel_d = dec_sel;
                        if (cur_ack) begin
                            cpud_ack   = 1'b1;
                            cpud_rdata = cur_rdata;
                        end else begin
                            state_d = S_WAIT;
                            timer_d = '0;
                        end
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end

            S_WAIT: begin
                // A target ack in the final timeout cycle takes precedence.
                if (cur_ack) begin
                    cpud_ack   = 1'b1;
                    cpud_rdata = cur_rdata;
                    state_d    = S_IDLE;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    cpud_ack   = 1'b1;
                    cpud_error = 1'b1;
                    cpud_rdata = ERR_RDATA;
                    state_d    = S_IDLE;
                end else if (timer_q != {TW{1'b1}}) begin
                    timer_d = timer_q + 1'b1;
                end
            end

            S_ERR: begin
                cpud_ack   = 1'b1;
                cpud_error = 1'b1;
                cpud_rdata = ERR_RDATA;
                state_d    = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        // Outputs are held quiet for the whole reset cycle, not just after it.
        if (!resetn) begin
            tgt_req    = '0;
            cpud_ack   = 1'b0;
            cpud_error = 1'b0;
            cpud_rdata = '0;
        end
    end

    // NOTE: state registers use non-blocking '<=' so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            timer_q <= timer_d;
        end
    end

`ifdef BUS_ERROR_LOG_EN
    // The failing request's address is gone by the time a timeout or unmapped
    // error is acked, so it is held from the accepted request.
    logic [31:0] req_addr_q;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            req_addr_q <= '0;
        end else if (state_q == S_IDLE && cpud_request) begin
            req_addr_q <= cpud_addr;
        end
    end

    // A new error in the same cycle as err_clear is captured, not lost.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
        end else if (cpud_ack && cpud_error && (!err_valid || err_clear)) begin
            err_valid <= 1'b1;
            err_addr  <= req_addr_q;
        end else if (err_clear) begin
            err_valid <= 1'b0;
        end
    end
`endif

endmodule
